// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling swap loop: walks i over S, accumulates j from S[i] and the key,
// and swaps S[i]/S[j] through a single synchronous-read RAM port (6 cycles per i).
module ksa_shuffle #(
  parameter int KEY_BYTES  = 3,
  parameter int ITERATIONS = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             s_q,
  output logic [7:0]             s_address,
  output logic [7:0]             s_data,
  output logic                   s_wren,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             dbg_state
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_I  = 3'd1,
    CAP_I = 3'd2,
    RD_J  = 3'd3,
    CAP_J = 3'd4,
    WR_I  = 3'd5,
    WR_J  = 3'd6,
    DONE  = 3'd7
  } state_t;

  // Handshake: start is a level, sampled only in IDLE/DONE; busy covers every other
  // state and done is held in DONE until the next accepted start.
  state_t        r_state;
  logic [7:0]    r_i;
  logic [7:0]    r_j;
  logic [7:0]    r_si;
  logic [KW-1:0] r_kidx;

  logic [7:0]    w_key_byte;
  logic [7:0]    w_j_next;
  logic [KW-1:0] w_kidx_next;
  logic          w_last;

  always_comb begin
    w_key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (r_kidx == KW'(k)) w_key_byte = secret_key[8*(KEY_BYTES-k)-1 -: 8];
    end
  end

  assign w_j_next    = r_j + s_q + w_key_byte;
  assign w_kidx_next = (r_kidx == KW'(KEY_BYTES - 1)) ? '0 : r_kidx + KW'(1);
  assign w_last      = (r_i == 8'(ITERATIONS - 1));
  assign dbg_state   = r_state;

  // The s_data register captured in CAP_J is S[j] itself, so no separate sj copy is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_si      <= '0;
      r_kidx    <= '0;
      s_address <= '0;
      s_data    <= '0;
      s_wren    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state   <= RD_I;
            r_i       <= '0;
            r_j       <= '0;
            r_kidx    <= '0;
            s_address <= '0;
            s_wren    <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        RD_I: r_state <= CAP_I;
        CAP_I: begin
          r_si      <= s_q;
          r_j       <= w_j_next;
          s_address <= w_j_next;
          r_state   <= RD_J;
        end
        RD_J: r_state <= CAP_J;
        CAP_J: begin
          s_address <= r_i;
          s_data    <= s_q;
          s_wren    <= 1'b1;
          r_state   <= WR_I;
        end
        WR_I: begin
          s_address <= r_j;
          s_data    <= r_si;
          r_state   <= WR_J;
        end
        WR_J: begin
          s_wren <= 1'b0;
          if (w_last) begin
            s_address <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_i       <= r_i + 8'd1;
            r_kidx    <= w_kidx_next;
            s_address <= r_i + 8'd1;
            r_state   <= RD_I;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ksa_shuffle.md
Name: ksa_shuffle

Overview:
- Second RC4 stage (key-scheduling swap loop). Runs after the S-memory initialiser has written S[i]=i for i=0..255.
- Reads and writes the same 256x8 S RAM through its own address/data/wren port. The top level muxes that port onto the RAM once the initialiser reports done.
- Uses the 24-bit secret_key that the top level also shows on HEX5..HEX0.
- Asserts done when S holds the scheduled permutation, ready for the PRGA/decrypt stage.

Parameters:
- KEY_BYTES, 3: key length in bytes; key byte k = secret_key[8*(KEY_BYTES-k)-1 -: 8], so byte 0 is secret_key[23:16].
- ITERATIONS, 256: number of i values processed, i = 0..ITERATIONS-1.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-low reset (KEY[3]).
- start  in  1  active-high; sampled only in IDLE or DONE.
- secret_key  in  24  key; must be held stable while busy.
- s_q  in  8  RAM read data; valid in the cycle after the address is driven.
- s_address  out  8  RAM address.
- s_data  out  8  RAM write data.
- s_wren  out  1  RAM write enable.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Algorithm: j=0; for i=0..255 { j = (j + S[i] + key[i mod KEY_BYTES]) mod 256; swap S[i], S[j] }. All sums are 8-bit with wrap; no carry is kept.
- Registers: i[7:0], j[7:0], si[7:0], sj[7:0], kidx[1:0] (mod-3 counter, so no divider).
- Reset (async, active-low):
  - state=IDLE; i=j=si=sj=kidx=0.
  - s_address=0, s_data=0, s_wren=0, busy=0, done=0.
- Reset asserted mid-run aborts immediately. The RAM is left partially shuffled and no recovery is attempted.
- FSM, one state per cycle:
  - IDLE: outputs idle (s_wren=0, s_address=0). On start=1 → RD_I, with i=0, j=0, kidx=0.
  - RD_I: s_address=i, s_wren=0 → CAP_I.
  - CAP_I: si<=s_q; j<=j+s_q+keybyte[kidx] → RD_J.
  - RD_J: s_address=j (the updated value), s_wren=0 → CAP_J.
  - CAP_J: sj<=s_q → WR_I.
  - WR_I: s_address=i, s_data=sj, s_wren=1 → WR_J.
  - WR_J:
    - s_address=j, s_data=si, s_wren=1.
    - If i==ITERATIONS-1 → DONE.
    - Else i<=i+1 and kidx<=(kidx==KEY_BYTES-1)?0:kidx+1 → RD_I.
  - DONE:
    - done=1, s_wren=0; hold indefinitely.
    - On start=1 → RD_I with i=j=kidx=0; done drops the next cycle.
- Latency:
  - 6 cycles per iteration; 1536 cycles for the full run.
  - start sampled at edge E0 → busy=1 from E0 through E0+1536 → done=1 at edge E0+1536.
- s_wren is high only in WR_I and WR_J: exactly 512 write cycles per run.
- Boundary i==j: WR_I and WR_J both write the same value to the same address. The result is correct, with no special case.
- start held high continuously: no effect while busy. From DONE it restarts every 1537 cycles.
- start is already debounced/synchronised upstream and needs no edge detection here.
- i wraps 255→0 only via the DONE/restart path. It never increments past 255 within a run.

Test Plan:
- Reset: assert reset=0 during CAP_J of iteration 10 → s_wren=0, busy=0, done=0 and state IDLE within the same cycle (async); no further writes.
- Key 0x00033C, S preloaded with S[i]=i, pulse start:
  - Iteration 0: j=0x00; both writes to addr 0 with data 0x00.
  - Iteration 1: j=0x04 → S[1]=0x04, S[4]=0x01.
  - Iteration 2: j=0x42 → S[2]=0x42, S[0x42]=0x02.
- Key 0x000000, identity S:
  - Iterations 0,1: i==j, so S is unchanged.
  - Iteration 2: j=3 → S[2]=3, S[3]=2.
  - Iteration 3: j=5 → S[3]=5, S[5]=2.
- Full run, key 0x00033C: done rises exactly 1536 cycles after the start edge. The final S matches a software RC4 KSA model byte-for-byte, and the bench counts exactly 512 s_wren cycles.
- Control edges:
  - start pulsed while busy (iteration 100) → ignored; done timing unchanged.
  - start pulsed in DONE → done falls the next cycle and a second run completes 1536 cycles later.
